ahb_bm_output_rr_arbiter: RTL and testbench

- Round-robin arbiter for one bus-matrix output stage; sits beside the output-stage mux and produces the address-phase port select for the shared slave.
- Resolves requests from NUM_PORTS input stages.
- Holds the grant across locked sequences and across fixed-length bursts so they are never split.
- Releases the grant at burst end, on an IDLE transfer, or on early burst termination.

---
 rtl/ahb_bm_pkg.sv | 29 ++
 rtl/ahb_bm_rr_pick.sv | 25 ++
 rtl/ahb_bm_output_rr_arbiter.sv | 74 +++++++
 tb/tb_ahb_bm_output_rr_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/ahb_bm_pkg.sv
// ahb_bm_pkg: AHB transfer/burst encodings shared by the bus-matrix output stage.
package ahb_bm_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    // Beats remaining after the NONSEQ beat; undefined-length bursts count as single.
    function automatic logic [3:0] burst_beats_m1(input logic [2:0] hburst);
        return (hburst[2:1] == 2'b01) ? 4'd3  :
               (hburst[2:1] == 2'b10) ? 4'd7  :
               (hburst[2:1] == 2'b11) ? 4'd15 : 4'd0;
    endfunction

endpackage

// File: rtl/ahb_bm_rr_pick.sv
// ahb_bm_rr_pick: combinational rotating-priority picker; the port after 'last' has top priority.
module ahb_bm_rr_pick #(
    parameter int N = 3,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] grant_idx,
    output logic         any_req
);

    logic [W-1:0] idx;

    // Scan from lowest to highest priority so the nearest requester is written last.
    always_comb begin
        grant_idx = '0;
        idx       = '0;
        any_req   = |req;
        for (int i = N; i >= 1; i--) begin
            idx = W'((int'(last) + i) % N);
            if (req[idx]) grant_idx = idx;
        end
    end

endmodule

// File: rtl/ahb_bm_output_rr_arbiter.sv
// ahb_bm_output_rr_arbiter: round-robin address-phase port select for one bus-matrix output stage,
// holding the grant across locked sequences and fixed-length bursts.
module ahb_bm_output_rr_arbiter
    import ahb_bm_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic                 no_port
);

    logic [PORT_W-1:0] addr_q, addr_d, rr_last_q, rr_last_d, grant_idx;
    logic              no_port_q, no_port_d, any_req, accept, hold_grant;
    logic [3:0]        burst_cnt_q, burst_cnt_d;

    ahb_bm_rr_pick #(.N(NUM_PORTS), .W(PORT_W)) u_pick (
        .req       (req_port),
        .last      (rr_last_q),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    always_comb begin
        accept      = HREADYM & HSELM & ~no_port_q;
        burst_cnt_d = !HREADYM                                    ? burst_cnt_q :
                      (!HSELM || HTRANSM == HTRANS_IDLE)          ? 4'd0 :
                      (accept && HTRANSM == HTRANS_NONSEQ)        ? burst_beats_m1(HBURSTM) :
                      (accept && HTRANSM == HTRANS_SEQ && burst_cnt_q != 4'd0) ? burst_cnt_q - 4'd1 :
                      burst_cnt_q;
        // Post-update count lets the final beat of a fixed burst release in its own cycle.
        hold_grant  = ~no_port_q & (HMASTLOCKM | (burst_cnt_d != 4'd0) | (HTRANSM == HTRANS_BUSY));
        addr_d      = addr_q;
        no_port_d   = no_port_q;
        rr_last_d   = rr_last_q;
        if (HREADYM) begin
            if (hold_grant) begin
                no_port_d = 1'b0;
            end else if (any_req) begin
                addr_d    = grant_idx;
                no_port_d = 1'b0;
                rr_last_d = grant_idx;
            end else begin
                no_port_d = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q      <= '0;
            no_port_q   <= 1'b1;
            burst_cnt_q <= 4'd0;
            rr_last_q   <= PORT_W'(NUM_PORTS - 1);
        end else begin
            addr_q      <= addr_d;
            no_port_q   <= no_port_d;
            burst_cnt_q <= burst_cnt_d;
            rr_last_q   <= rr_last_d;
        end
    end

    assign addr_in_port = addr_q;
    assign no_port      = no_port_q;

endmodule

// File: tb/tb_ahb_bm_output_rr_arbiter.sv
// tb_ahb_bm_output_rr_arbiter: directed self-checking bench for the output-stage round-robin arbiter.
module tb_ahb_bm_output_rr_arbiter;
    import ahb_bm_pkg::*;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic [2:0] req_port;
    logic       HREADYM, HSELM, HMASTLOCKM;
    logic [1:0] HTRANSM;
    logic [2:0] HBURSTM;
    logic [1:0] addr_in_port;
    logic       no_port;
    int         checks = 0;
    int         errors = 0;

    ahb_bm_output_rr_arbiter #(.NUM_PORTS(3)) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .req_port     (req_port),
        .HREADYM      (HREADYM),
        .HSELM        (HSELM),
        .HTRANSM      (HTRANSM),
        .HBURSTM      (HBURSTM),
        .HMASTLOCKM   (HMASTLOCKM),
        .addr_in_port (addr_in_port),
        .no_port      (no_port)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic cyc(input logic [2:0] r, input logic rdy, input logic sel,
                       input logic [1:0] t, input logic [2:0] b, input logic lk);
        req_port   = r;
        HREADYM    = rdy;
        HSELM      = sel;
        HTRANSM    = t;
        HBURSTM    = b;
        HMASTLOCKM = lk;
        tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        HRESETn = 1'b0; req_port = 3'b111; HREADYM = 1'b1; HSELM = 1'b0;
        HTRANSM = HTRANS_IDLE; HBURSTM = HBURST_SINGLE; HMASTLOCKM = 1'b0;
        tick(); tick();
        chk("rst_addr", 32'(addr_in_port), 0);
        chk("rst_nop", 32'(no_port), 1);
        HRESETn = 1'b1;
        // first grants rotate 0,1,2 and wrap back to 0
        cyc(3'b111, 1, 0, HTRANS_IDLE, HBURST_SINGLE, 0);
        chk("first_addr", 32'(addr_in_port), 0);
        chk("first_nop", 32'(no_port), 0);
        cyc(3'b111, 1, 1, HTRANS_IDLE, HBURST_SINGLE, 0);
        chk("rr_1", 32'(addr_in_port), 1);
        cyc(3'b111, 1, 1, HTRANS_IDLE, HBURST_SINGLE, 0);
        chk("rr_2", 32'(addr_in_port), 2);
        cyc(3'b111, 1, 1, HTRANS_IDLE, HBURST_SINGLE, 0);
        chk("rr_wrap", 32'(addr_in_port), 0);
        // port 1 INCR8 under contention
        cyc(3'b111, 1, 1, HTRANS_IDLE, HBURST_SINGLE, 0);
        chk("incr8_own", 32'(addr_in_port), 1);
        cyc(3'b111, 1, 1, HTRANS_NONSEQ, HBURST_INCR8, 0);
        chk("incr8_b1", 32'(addr_in_port), 1);
        for (int i = 0; i < 6; i++) begin
            cyc(3'b111, 1, 1, HTRANS_SEQ, HBURST_INCR8, 0);
            chk("incr8_seq", 32'(addr_in_port), 1);
        end
        cyc(3'b111, 1, 1, HTRANS_SEQ, HBURST_INCR8, 0);
        chk("incr8_end", 32'(addr_in_port), 2);
        // port 0 INCR4 with BUSY and wait states
        cyc(3'b111, 1, 1, HTRANS_IDLE, HBURST_SINGLE, 0);
        chk("incr4_own", 32'(addr_in_port), 0);
        cyc(3'b111, 1, 1, HTRANS_NONSEQ, HBURST_INCR4, 0);
        chk("incr4_b1", 32'(addr_in_port), 0);
        cyc(3'b111, 1, 1, HTRANS_SEQ, HBURST_INCR4, 0);
        chk("incr4_b2", 32'(addr_in_port), 0);
        cyc(3'b111, 1, 1, HTRANS_BUSY, HBURST_INCR4, 0);
        chk("incr4_busy", 32'(addr_in_port), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(3'b111, 0, 1, HTRANS_SEQ, HBURST_INCR4, 0);
            chk("incr4_wait", 32'(addr_in_port), 0);
        end
        cyc(3'b111, 1, 1, HTRANS_SEQ, HBURST_INCR4, 0);
        chk("incr4_b3", 32'(addr_in_port), 0);
        cyc(3'b111, 1, 1, HTRANS_SEQ, HBURST_INCR4, 0);
        chk("incr4_end", 32'(addr_in_port), 1);
        // port 2 locked, HSELM drops mid-lock
        cyc(3'b111, 1, 1, HTRANS_IDLE, HBURST_SINGLE, 0);
        chk("lock_own", 32'(addr_in_port), 2);
        cyc(3'b101, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 1);
        chk("lock_t1", 32'(addr_in_port), 2);
        for (int i = 0; i < 2; i++) begin
            cyc(3'b101, 1, 0, HTRANS_IDLE, HBURST_SINGLE, 1);
            chk("lock_nosel", 32'(addr_in_port), 2);
        end
        cyc(3'b101, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 1);
        chk("lock_t2", 32'(addr_in_port), 2);
        cyc(3'b001, 1, 1, HTRANS_IDLE, HBURST_SINGLE, 0);
        chk("lock_rel", 32'(addr_in_port), 0);
        // port 0 INCR16 terminated early by IDLE
        cyc(3'b011, 1, 1, HTRANS_NONSEQ, HBURST_INCR16, 0);
        chk("early_b1", 32'(addr_in_port), 0);
        for (int i = 0; i < 4; i++) begin
            cyc(3'b011, 1, 1, HTRANS_SEQ, HBURST_INCR16, 0);
            chk("early_seq", 32'(addr_in_port), 0);
        end
        cyc(3'b011, 1, 1, HTRANS_IDLE, HBURST_INCR16, 0);
        chk("early_idle", 32'(addr_in_port), 1);
        cyc(3'b011, 1, 1, HTRANS_SEQ, HBURST_INCR16, 0);
        chk("early_cleared", 32'(addr_in_port), 0);
        // no requests
        cyc(3'b000, 1, 1, HTRANS_IDLE, HBURST_SINGLE, 0);
        chk("noreq_nop", 32'(no_port), 1);
        chk("noreq_addr", 32'(addr_in_port), 0);
        cyc(3'b000, 1, 1, HTRANS_NONSEQ, HBURST_INCR4, 0);
        chk("noreq_noacc", 32'(no_port), 1);
        cyc(3'b010, 0, 1, HTRANS_NONSEQ, HBURST_INCR4, 0);
        chk("noreq_stall", 32'(no_port), 1);
        cyc(3'b010, 1, 1, HTRANS_NONSEQ, HBURST_INCR4, 0);
        chk("req1_nop", 32'(no_port), 0);
        chk("req1_addr", 32'(addr_in_port), 1);
        // asynchronous reset mid-burst
        cyc(3'b111, 1, 1, HTRANS_NONSEQ, HBURST_INCR8, 0);
        chk("prerst_hold", 32'(addr_in_port), 1);
        #2 HRESETn = 1'b0;
        #1;
        chk("arst_addr", 32'(addr_in_port), 0);
        chk("arst_nop", 32'(no_port), 1);
        tick();
        HRESETn = 1'b1;
        cyc(3'b111, 1, 1, HTRANS_SEQ, HBURST_INCR8, 0);
        chk("postrst_p0", 32'(addr_in_port), 0);
        cyc(3'b111, 1, 1, HTRANS_SEQ, HBURST_INCR8, 0);
        chk("postrst_nocnt", 32'(addr_in_port), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
